pll_mdrp_ctrl: RTL

PLL_MDRP_CTRL -- requirements
Module: pll_mdrp_ctrl

---
 rtl/pll_mdrp_ctrl_if.sv | 23 ++
 rtl/pll_mdrp_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pll_mdrp_ctrl_if.sv
// Host request/response channel of the PLL mode-data port controller.
// The host side uses the master modport; the controller uses slave.
interface pll_mdrp_ctrl_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic       req_commit;
   logic [6:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;

   modport master (
      output req_valid, req_write, req_commit, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_commit, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/pll_mdrp_ctrl.sv
// PLL mode-data port controller: turns host read/write requests into address-load
// and opcode strobes, and for commit writes pulses the PLL reset and waits for lock.
module pll_mdrp_ctrl #(
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_TIMEOUT = 65535
) (
   input  logic           clk,
   input  logic           reset_n,
   pll_mdrp_ctrl_if.slave host,
   output logic [1:0]     mdopc,
   output logic           mdainc,
   output logic [7:0]     mdwdi,
   input  logic [7:0]     mdrdo,
   input  logic           pll_lock,
   output logic           pll_reset
);
   localparam logic [1:0]  OPC_NOP   = 2'b00;
   localparam logic [1:0]  OPC_WR    = 2'b01;
   localparam logic [1:0]  OPC_RD    = 2'b10;
   localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);
   localparam logic [15:0] LOCK_LAST = 16'(LOCK_TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, ADDR, OP, RD_W1, RD_W2, PRST, LOCKW, RSP} state_t;

   state_t      state, state_nxt;
   logic        hs;
   logic        ready_q;
   logic        wr_q, commit_q;
   logic [7:0]  wdata_q;
   logic        err_q, err_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic        lock_p0, lock_p1;
   logic [1:0]  mdopc_d;
   logic        mdainc_d;
   logic [7:0]  mdwdi_d;
   logic        rsp_valid_q, rsp_err_q;
   logic [7:0]  rsp_rdata_q;

   assign host.req_ready = ready_q;
   assign host.rsp_valid = rsp_valid_q;
   assign host.rsp_err   = rsp_err_q;
   assign host.rsp_rdata = rsp_rdata_q;

   // Next-state and next-output decode; every output is registered from these
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      err_nxt   = err_q;
      mdopc_d   = OPC_NOP;
      mdainc_d  = 1'b0;
      mdwdi_d   = 8'h00;
      hs        = host.req_valid && ready_q;
      unique case (state)
         IDLE: begin
            if (hs) begin
               state_nxt = ADDR;
               err_nxt   = 1'b0;
               mdainc_d  = 1'b1;
               mdwdi_d   = {1'b0, host.req_addr};
            end
         end
         ADDR: begin
            state_nxt = OP;
            mdopc_d   = wr_q ? OPC_WR : OPC_RD;
            mdwdi_d   = wr_q ? wdata_q : 8'h00;
         end
         OP: begin
            cnt_nxt = 16'h0000;
            if (!wr_q)         state_nxt = RD_W1;
            else if (commit_q) state_nxt = PRST;
            else               state_nxt = RSP;
         end
         RD_W1: state_nxt = RD_W2;
         RD_W2: state_nxt = RSP;
         PRST: begin
            if (cnt == RST_LAST) begin
               state_nxt = LOCKW;
               cnt_nxt   = 16'h0000;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         LOCKW: begin
            // lock is tested first so a lock arriving on the timeout cycle still succeeds
            if (lock_p1) begin
               state_nxt = RSP;
               err_nxt   = 1'b0;
            end else if (cnt == LOCK_LAST) begin
               state_nxt = RSP;
               err_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         RSP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State, lock synchronizer (p0 -> p1) and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         ready_q     <= 1'b0;
         wr_q        <= 1'b0;
         commit_q    <= 1'b0;
         wdata_q     <= 8'h00;
         err_q       <= 1'b0;
         cnt         <= 16'h0000;
         lock_p0     <= 1'b0;
         lock_p1     <= 1'b0;
         mdopc       <= OPC_NOP;
         mdainc      <= 1'b0;
         mdwdi       <= 8'h00;
         pll_reset   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 8'h00;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         err_q       <= err_nxt;
         lock_p0     <= pll_lock;
         lock_p1     <= lock_p0;
         ready_q     <= (state_nxt == IDLE);
         mdopc       <= mdopc_d;
         mdainc      <= mdainc_d;
         mdwdi       <= mdwdi_d;
         pll_reset   <= (state_nxt == PRST);
         rsp_valid_q <= (state_nxt == RSP);
         rsp_err_q   <= (state_nxt == RSP) && err_nxt;
         if (hs) begin
            wr_q     <= host.req_write;
            commit_q <= host.req_write && host.req_commit;
            wdata_q  <= host.req_wdata;
         end
         if (state == RD_W2) rsp_rdata_q <= mdrdo;
      end
   end
endmodule
